// File: rtl/host_cmd_master_pkg.sv
// Shared constants for the host command link: command encodings, frame
// opcodes and the master FSM state encoding.
package host_cmd_master_pkg;

  typedef enum logic [1:0] {
    CMD_WR      = 2'd0,
    CMD_RD      = 2'd1,
    CMD_ALU     = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_e;

  localparam logic [7:0] OPC_WR      = 8'hAA;
  localparam logic [7:0] OPC_RD      = 8'hBB;
  localparam logic [7:0] OPC_ALU     = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  // Index of the final byte of each frame (frames are 2..4 bytes long).
  function automatic logic [1:0] last_tx_idx(input cmd_type_e t);
    case (t)
      CMD_WR:  return 2'd2;
      CMD_ALU: return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [7:0] frame_opcode(input cmd_type_e t);
    case (t)
      CMD_WR:  return OPC_WR;
      CMD_RD:  return OPC_RD;
      CMD_ALU: return OPC_ALU;
      default: return OPC_ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Response timeout counter: held at zero while clr is high, otherwise counts
// up and saturates at TIMEOUT_CYC-1, where expired is raised.
module cmd_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != TERM) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == TERM);

endmodule

// File: rtl/host_cmd_master.sv
// Host command master: serialises register/ALU commands into UART frames and
// collects the response bytes, with a response timeout.
// Handshakes: a command is taken on CMD_VALID && CMD_READY; a TX byte moves on
// TX_BYTE_VALID && TX_BYTE_READY with TX_BYTE held stable until then; RX bytes
// are single-cycle strobes with no back-pressure.
module host_cmd_master
  import host_cmd_master_pkg::*;
#(
  parameter int DATA_WD     = 8,
  parameter int ADDR_WD     = 4,
  parameter int FUN_WD      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CMD_VALID,
  input  logic [1:0]           CMD_TYPE,
  input  logic [ADDR_WD-1:0]   CMD_ADDR,
  input  logic [DATA_WD-1:0]   CMD_OP_A,
  input  logic [DATA_WD-1:0]   CMD_OP_B,
  input  logic [FUN_WD-1:0]    CMD_FUN,
  output logic                 CMD_READY,
  output logic [DATA_WD-1:0]   TX_BYTE,
  output logic                 TX_BYTE_VALID,
  input  logic                 TX_BYTE_READY,
  input  logic [DATA_WD-1:0]   RX_BYTE,
  input  logic                 RX_BYTE_VALID,
  output logic [2*DATA_WD-1:0] RSP_DATA,
  output logic                 RSP_VALID,
  output logic                 RSP_TIMEOUT,
  output state_e               DBG_STATE
);

  state_e                 state_q, state_d;
  cmd_type_e              type_q, type_d;
  logic [ADDR_WD-1:0]     addr_q, addr_d;
  logic [DATA_WD-1:0]     op_a_q, op_a_d;
  logic [DATA_WD-1:0]     op_b_q, op_b_d;
  logic [FUN_WD-1:0]      fun_q, fun_d;
  logic [1:0]             idx_q, idx_d;
  logic                   rx_cnt_q, rx_cnt_d;
  logic [DATA_WD-1:0]     rx_lo_q, rx_lo_d;
  logic [2*DATA_WD-1:0]   rsp_data_q, rsp_data_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_timeout_q, rsp_timeout_d;

  logic                   to_clr;
  logic                   to_expired;
  logic                   last_byte;
  logic [DATA_WD-1:0]     tx_byte;

  // Counter runs only in WAIT_RSP; any RX byte restarts the window.
  assign to_clr = (state_q != ST_WAIT_RSP) || RX_BYTE_VALID;

  cmd_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (CLK),
    .rst     (RST),
    .clr     (to_clr),
    .expired (to_expired)
  );

  assign last_byte = (idx_q == last_tx_idx(type_q));

  always_comb begin
    tx_byte = '0;
    if (state_q == ST_SEND) begin
      case (type_q)
        CMD_WR: begin
          case (idx_q)
            2'd0:    tx_byte = DATA_WD'(frame_opcode(type_q));
            2'd1:    tx_byte = DATA_WD'(addr_q);
            default: tx_byte = op_a_q;
          endcase
        end
        CMD_RD: begin
          tx_byte = (idx_q == 2'd0) ? DATA_WD'(frame_opcode(type_q)) : DATA_WD'(addr_q);
        end
        CMD_ALU: begin
          case (idx_q)
            2'd0:    tx_byte = DATA_WD'(frame_opcode(type_q));
            2'd1:    tx_byte = op_a_q;
            2'd2:    tx_byte = op_b_q;
            default: tx_byte = DATA_WD'(fun_q);
          endcase
        end
        default: begin
          tx_byte = (idx_q == 2'd0) ? DATA_WD'(frame_opcode(type_q)) : DATA_WD'(fun_q);
        end
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    addr_d        = addr_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    fun_d         = fun_q;
    idx_d         = idx_q;
    rx_cnt_d      = rx_cnt_q;
    rx_lo_d       = rx_lo_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          type_d   = cmd_type_e'(CMD_TYPE);
          addr_d   = CMD_ADDR;
          op_a_d   = CMD_OP_A;
          op_b_d   = CMD_OP_B;
          fun_d    = CMD_FUN;
          idx_d    = 2'd0;
          rx_cnt_d = 1'b0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (TX_BYTE_READY) begin
          if (last_byte) begin
            idx_d = 2'd0;
            if (type_q == CMD_WR) begin
              rsp_data_d  = '0;
              rsp_valid_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              state_d = ST_WAIT_RSP;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_WAIT_RSP: begin
        // An RX byte wins over a coincident timeout terminal count.
        if (RX_BYTE_VALID) begin
          if (type_q == CMD_RD) begin
            rsp_data_d  = {{DATA_WD{1'b0}}, RX_BYTE};
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (!rx_cnt_q) begin
            rx_lo_d  = RX_BYTE;
            rx_cnt_d = 1'b1;
          end else begin
            rsp_data_d  = {RX_BYTE, rx_lo_q};
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (to_expired) begin
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      type_q        <= CMD_WR;
      addr_q        <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      fun_q         <= '0;
      idx_q         <= '0;
      rx_cnt_q      <= 1'b0;
      rx_lo_q       <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      addr_q        <= addr_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      fun_q         <= fun_d;
      idx_q         <= idx_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_lo_q       <= rx_lo_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign CMD_READY     = (state_q == ST_IDLE);
  assign TX_BYTE       = tx_byte;
  assign TX_BYTE_VALID = (state_q == ST_SEND);
  assign RSP_DATA      = rsp_data_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_TIMEOUT   = rsp_timeout_q;
  assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_host_cmd_master.sv
// Directed bench for host_cmd_master: frame bytes, response capture,
// backpressure, timeout window and mid-frame reset.
module tb_host_cmd_master;
  import host_cmd_master_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int TO = 16;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            CMD_VALID = 1'b0;
  logic [1:0]      CMD_TYPE = '0;
  logic [AW-1:0]   CMD_ADDR = '0;
  logic [DW-1:0]   CMD_OP_A = '0;
  logic [DW-1:0]   CMD_OP_B = '0;
  logic [FW-1:0]   CMD_FUN = '0;
  logic            CMD_READY;
  logic [DW-1:0]   TX_BYTE;
  logic            TX_BYTE_VALID;
  logic            TX_BYTE_READY = 1'b1;
  logic [DW-1:0]   RX_BYTE = '0;
  logic            RX_BYTE_VALID = 1'b0;
  logic [2*DW-1:0] RSP_DATA;
  logic            RSP_VALID;
  logic            RSP_TIMEOUT;
  state_e          DBG_STATE;

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] frm_b[4];
  int            frm_c[4];
  int            frm_got;
  bit            frm_stable;

  host_cmd_master #(
    .DATA_WD(DW), .ADDR_WD(AW), .FUN_WD(FW), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR),
    .CMD_OP_A(CMD_OP_A), .CMD_OP_B(CMD_OP_B), .CMD_FUN(CMD_FUN),
    .CMD_READY(CMD_READY),
    .TX_BYTE(TX_BYTE), .TX_BYTE_VALID(TX_BYTE_VALID), .TX_BYTE_READY(TX_BYTE_READY),
    .RX_BYTE(RX_BYTE), .RX_BYTE_VALID(RX_BYTE_VALID),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_TIMEOUT(RSP_TIMEOUT),
    .DBG_STATE(DBG_STATE)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  // Drivers: called at a negedge with the DUT idle; returns just after the accept edge.
  task automatic issue_cmd(input logic [1:0] t, input logic [AW-1:0] a,
                           input logic [DW-1:0] opa, input logic [DW-1:0] opb,
                           input logic [FW-1:0] f);
    CMD_TYPE  = t;
    CMD_ADDR  = a;
    CMD_OP_A  = opa;
    CMD_OP_B  = opb;
    CMD_FUN   = f;
    CMD_VALID = 1'b1;
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
  endtask

  // Records bytes moved on TX; READY is decided for the coming edge before sampling.
  // READY is held low for stall_len edges while byte stall_idx is pending.
  task automatic collect_frame(input int n, input int stall_idx, input int stall_len);
    int left;
    logic [DW-1:0] held;
    bit have_held;
    left = stall_len;
    have_held = 1'b0;
    held = '0;
    frm_got = 0;
    frm_stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frm_b[i] = 'x;
      frm_c[i] = -1;
    end
    TX_BYTE_READY = 1'b1;
    for (int c = 0; c < 60 && frm_got < n; c++) begin
      @(negedge CLK);
      if (frm_got == stall_idx && left > 0) begin
        TX_BYTE_READY = 1'b0;
        left--;
      end else begin
        TX_BYTE_READY = 1'b1;
      end
      if (TX_BYTE_VALID) begin
        if (TX_BYTE_READY) begin
          frm_b[frm_got] = TX_BYTE;
          frm_c[frm_got] = c;
          frm_got++;
          have_held = 1'b0;
        end else begin
          if (have_held && TX_BYTE !== held) frm_stable = 1'b0;
          held = TX_BYTE;
          have_held = 1'b1;
        end
      end
    end
    TX_BYTE_READY = 1'b1;
  endtask

  // Called at a negedge; returns at the next negedge with the strobe dropped.
  task automatic send_rx(input logic [DW-1:0] v);
    RX_BYTE = v;
    RX_BYTE_VALID = 1'b1;
    @(negedge CLK);
    RX_BYTE_VALID = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    compared++; if (CMD_READY !== 1'b1) begin mismatched++; $display("FAIL rst_cmd_ready: got %b want 1", CMD_READY); end
    compared++; if (TX_BYTE !== 8'h00) begin mismatched++; $display("FAIL rst_tx_byte: got %h want 00", TX_BYTE); end
    compared++; if (TX_BYTE_VALID !== 1'b0) begin mismatched++; $display("FAIL rst_tx_valid: got %b want 0", TX_BYTE_VALID); end
    compared++; if (RSP_DATA !== 16'h0000) begin mismatched++; $display("FAIL rst_rsp_data: got %h want 0000", RSP_DATA); end
    compared++; if (RSP_VALID !== 1'b0 || RSP_TIMEOUT !== 1'b0) begin mismatched++; $display("FAIL rst_rsp_flags: got v=%b t=%b want 0 0", RSP_VALID, RSP_TIMEOUT); end
    RST = 1'b0;
    @(negedge CLK);
    compared++; if (DBG_STATE !== ST_IDLE || CMD_READY !== 1'b1) begin mismatched++; $display("FAIL rst_release_idle: got state=%0d ready=%b want 0 1", DBG_STATE, CMD_READY); end
  endtask

  task automatic test_write;
    logic [7:0] exp[3] = '{8'hAA, 8'h05, 8'h3C};
    @(negedge CLK);
    issue_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
    collect_frame(3, -1, 0);
    compared++; if (frm_got !== 3) begin mismatched++; $display("FAIL wr_count: got %0d want 3", frm_got); end
    for (int i = 0; i < 3; i++) begin
      compared++; if (frm_b[i] !== exp[i]) begin mismatched++; $display("FAIL wr_byte%0d: got %h want %h", i, frm_b[i], exp[i]); end
    end
    compared++; if (frm_c[0] !== 0 || frm_c[2] !== 2) begin mismatched++; $display("FAIL wr_timing: got first=%0d last=%0d want 0 2", frm_c[0], frm_c[2]); end
    @(negedge CLK);
    compared++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h0000) begin mismatched++; $display("FAIL wr_rsp: got v=%b d=%h want 1 0000", RSP_VALID, RSP_DATA); end
    compared++; if (CMD_READY !== 1'b1 || TX_BYTE_VALID !== 1'b0) begin mismatched++; $display("FAIL wr_idle: got ready=%b txv=%b want 1 0", CMD_READY, TX_BYTE_VALID); end
    @(negedge CLK);
    compared++; if (RSP_VALID !== 1'b0) begin mismatched++; $display("FAIL wr_rsp_pulse: got %b want 0", RSP_VALID); end
  endtask

  task automatic test_read;
    @(negedge CLK);
    send_rx(8'hEE);
    compared++; if (RSP_VALID !== 1'b0 || RSP_DATA !== 16'h0000) begin mismatched++; $display("FAIL rd_idle_rx_ignored: got v=%b d=%h want 0 0000", RSP_VALID, RSP_DATA); end
    issue_cmd(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
    collect_frame(2, -1, 0);
    compared++; if (frm_got !== 2 || frm_b[0] !== 8'hBB || frm_b[1] !== 8'h02) begin mismatched++; $display("FAIL rd_frame: got n=%0d %h %h want 2 BB 02", frm_got, frm_b[0], frm_b[1]); end
    @(negedge CLK);
    compared++; if (TX_BYTE_VALID !== 1'b0 || DBG_STATE !== ST_WAIT_RSP) begin mismatched++; $display("FAIL rd_wait: got txv=%b state=%0d want 0 2", TX_BYTE_VALID, DBG_STATE); end
    send_rx(8'h81);
    compared++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h0081) begin mismatched++; $display("FAIL rd_rsp: got v=%b d=%h want 1 0081", RSP_VALID, RSP_DATA); end
    compared++; if (CMD_READY !== 1'b1 || RSP_TIMEOUT !== 1'b0) begin mismatched++; $display("FAIL rd_done: got ready=%b to=%b want 1 0", CMD_READY, RSP_TIMEOUT); end
  endtask

  task automatic test_alu;
    logic [7:0] exp[4] = '{8'hCC, 8'h12, 8'h34, 8'h00};
    @(negedge CLK);
    issue_cmd(2'd2, 4'h0, 8'h12, 8'h34, 4'h0);
    collect_frame(4, -1, 0);
    compared++; if (frm_got !== 4) begin mismatched++; $display("FAIL alu_count: got %0d want 4", frm_got); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (frm_b[i] !== exp[i]) begin mismatched++; $display("FAIL alu_byte%0d: got %h want %h", i, frm_b[i], exp[i]); end
    end
    @(negedge CLK);
    send_rx(8'h46);
    compared++; if (RSP_VALID !== 1'b0 || RSP_DATA !== 16'h0081) begin mismatched++; $display("FAIL alu_first_rx_hold: got v=%b d=%h want 0 0081", RSP_VALID, RSP_DATA); end
    repeat (2) @(negedge CLK);
    send_rx(8'h00);
    compared++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h0046) begin mismatched++; $display("FAIL alu_rsp: got v=%b d=%h want 1 0046", RSP_VALID, RSP_DATA); end
  endtask

  task automatic test_timeout;
    int to_at;
    bit saw_valid;
    to_at = -1;
    saw_valid = 1'b0;
    @(negedge CLK);
    issue_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h9);
    collect_frame(2, -1, 0);
    compared++; if (frm_got !== 2 || frm_b[0] !== 8'hDD || frm_b[1] !== 8'h09) begin mismatched++; $display("FAIL to_frame: got n=%0d %h %h want 2 DD 09", frm_got, frm_b[0], frm_b[1]); end
    for (int k = 0; k < 40 && to_at < 0; k++) begin
      @(negedge CLK);
      if (RSP_VALID) saw_valid = 1'b1;
      if (RSP_TIMEOUT) to_at = k;
    end
    compared++; if (to_at !== TO) begin mismatched++; $display("FAIL to_latency: got %0d want %0d", to_at, TO); end
    compared++; if (saw_valid !== 1'b0) begin mismatched++; $display("FAIL to_no_rsp_valid: got %b want 0", saw_valid); end
    compared++; if (CMD_READY !== 1'b1 || RSP_DATA !== 16'h0046) begin mismatched++; $display("FAIL to_idle: got ready=%b d=%h want 1 0046", CMD_READY, RSP_DATA); end
    @(negedge CLK);
    compared++; if (RSP_TIMEOUT !== 1'b0) begin mismatched++; $display("FAIL to_pulse: got %b want 0", RSP_TIMEOUT); end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp[4] = '{8'hCC, 8'h5A, 8'hA5, 8'h0F};
    @(negedge CLK);
    issue_cmd(2'd2, 4'h0, 8'h5A, 8'hA5, 4'hF);
    collect_frame(4, 1, 5);
    compared++; if (frm_got !== 4) begin mismatched++; $display("FAIL bp_count: got %0d want 4", frm_got); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (frm_b[i] !== exp[i]) begin mismatched++; $display("FAIL bp_byte%0d: got %h want %h", i, frm_b[i], exp[i]); end
    end
    compared++; if (frm_stable !== 1'b1) begin mismatched++; $display("FAIL bp_stable: got %b want 1", frm_stable); end
    compared++; if (frm_c[1] - frm_c[0] !== 6 || frm_c[3] - frm_c[1] !== 2) begin mismatched++; $display("FAIL bp_timing: got %0d %0d want 6 2", frm_c[1] - frm_c[0], frm_c[3] - frm_c[1]); end
    @(negedge CLK);
    send_rx(8'h11);
    send_rx(8'h22);
    compared++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h2211) begin mismatched++; $display("FAIL bp_rsp: got v=%b d=%h want 1 2211", RSP_VALID, RSP_DATA); end
  endtask

  task automatic test_back_to_back;
    @(negedge CLK);
    issue_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h7);
    collect_frame(2, -1, 0);
    compared++; if (frm_b[0] !== 8'hDD || frm_b[1] !== 8'h07) begin mismatched++; $display("FAIL b2b_frame: got %h %h want DD 07", frm_b[0], frm_b[1]); end
    @(negedge CLK);
    send_rx(8'h34);
    send_rx(8'h12);
    compared++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h1234 || CMD_READY !== 1'b1) begin mismatched++; $display("FAIL b2b_rsp: got v=%b d=%h ready=%b want 1 1234 1", RSP_VALID, RSP_DATA, CMD_READY); end
    issue_cmd(2'd0, 4'hF, 8'hFF, 8'h00, 4'h0);
    collect_frame(3, -1, 0);
    compared++; if (frm_c[0] !== 0 || frm_b[0] !== 8'hAA || frm_b[1] !== 8'h0F || frm_b[2] !== 8'hFF) begin mismatched++; $display("FAIL b2b_wr_frame: got c0=%0d %h %h %h want 0 AA 0F FF", frm_c[0], frm_b[0], frm_b[1], frm_b[2]); end
    @(negedge CLK);
    compared++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h0000) begin mismatched++; $display("FAIL b2b_wr_rsp: got v=%b d=%h want 1 0000", RSP_VALID, RSP_DATA); end
  endtask

  task automatic test_timeout_boundary;
    bit saw_to;
    saw_to = 1'b0;
    @(negedge CLK);
    issue_cmd(2'd1, 4'hF, 8'h00, 8'h00, 4'h0);
    collect_frame(2, -1, 0);
    compared++; if (frm_b[0] !== 8'hBB || frm_b[1] !== 8'h0F) begin mismatched++; $display("FAIL tb_frame: got %h %h want BB 0F", frm_b[0], frm_b[1]); end
    for (int k = 0; k < TO; k++) begin
      @(negedge CLK);
      if (RSP_TIMEOUT) saw_to = 1'b1;
    end
    send_rx(8'h7E);
    if (RSP_TIMEOUT) saw_to = 1'b1;
    compared++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h007E) begin mismatched++; $display("FAIL tb_rx_priority: got v=%b d=%h want 1 007E", RSP_VALID, RSP_DATA); end
    @(negedge CLK);
    if (RSP_TIMEOUT) saw_to = 1'b1;
    compared++; if (saw_to !== 1'b0) begin mismatched++; $display("FAIL tb_no_timeout: got %b want 0", saw_to); end
  endtask

  task automatic test_reset_midframe;
    int idle_bad;
    idle_bad = 0;
    @(negedge CLK);
    issue_cmd(2'd2, 4'h0, 8'h01, 8'h02, 4'h3);
    collect_frame(2, -1, 0);
    @(negedge CLK);
    compared++; if (TX_BYTE_VALID !== 1'b1 || TX_BYTE !== 8'h02) begin mismatched++; $display("FAIL rm_pre: got txv=%b tx=%h want 1 02", TX_BYTE_VALID, TX_BYTE); end
    #1 RST = 1'b1;
    #1;
    compared++; if (TX_BYTE_VALID !== 1'b0 || TX_BYTE !== 8'h00 || CMD_READY !== 1'b1) begin mismatched++; $display("FAIL rm_tx_reset: got txv=%b tx=%h ready=%b want 0 00 1", TX_BYTE_VALID, TX_BYTE, CMD_READY); end
    compared++; if (RSP_DATA !== 16'h0000 || RSP_VALID !== 1'b0 || RSP_TIMEOUT !== 1'b0) begin mismatched++; $display("FAIL rm_rsp_reset: got d=%h v=%b t=%b want 0000 0 0", RSP_DATA, RSP_VALID, RSP_TIMEOUT); end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (TX_BYTE_VALID !== 1'b0 || CMD_READY !== 1'b1) idle_bad++;
    end
    compared++; if (idle_bad !== 0) begin mismatched++; $display("FAIL rm_idle_after: got %0d busy cycles want 0", idle_bad); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_timeout_boundary();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
